// File: rtl/logicnet_input_packer_if.sv
// Raw-feature input stream and packed-vector output stream of logicnet_input_packer.
// master = upstream feeder / downstream consumer side, slave = the packer itself.
interface logicnet_input_packer_if #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_W         = 8,
  parameter int unsigned BW           = 2
);
  logic                         s_valid;
  logic                         s_ready;
  logic [IN_W-1:0]              s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [NUM_FEATURES*BW-1:0]   m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/logicnet_input_packer.sv
// Quantizes raw features (shift + saturate) and packs NUM_FEATURES codes into one registered vector.
// Optional macro LOGICNET_PACKER_ERRCNT_EN builds a saturating framing-error counter on err_count.
module logicnet_input_packer #(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned IN_W         = 8,
  parameter int unsigned BW           = 2,
  parameter int unsigned SHIFT        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  logicnet_input_packer_if.slave  bus,
  output logic                    frame_err,
  output logic [15:0]             err_count
);

  localparam int unsigned VEC_W = NUM_FEATURES * BW;
  localparam int unsigned IDX_W = $clog2(NUM_FEATURES);
  localparam logic [IN_W-1:0] QMAX = IN_W'((2 ** BW) - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   asm_q, asm_d;
  logic [VEC_W-1:0]   m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               fe_q, fe_d;

  logic [IN_W-1:0]    shifted;
  logic [BW-1:0]      code;
  logic [VEC_W-1:0]   vec;
  logic               accept;
  logic               at_end;
  logic               complete;
  logic               slot_free;

  always_comb begin
    shifted   = bus.s_data >> SHIFT;
    code      = (shifted > QMAX) ? QMAX[BW-1:0] : shifted[BW-1:0];
    accept    = bus.s_valid && (state_q == FILL);
    at_end    = (idx_q == IDX_W'(NUM_FEATURES - 1));
    complete  = accept && (at_end || bus.s_last);
    slot_free = !m_valid_q || bus.m_ready;
    // Slots above idx are still zero from the post-completion clear, so early last zero-fills for free.
    vec = asm_q;
    vec[int'(idx_q) * int'(BW) +: BW] = code;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    fe_d      = accept && (at_end != bus.s_last);

    unique case (state_q)
      FILL: begin
        if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
        if (accept) begin
          idx_d = idx_q + IDX_W'(1);
          asm_d = vec;
        end
        if (complete) begin
          idx_d = '0;
          if (slot_free) begin
            m_data_d  = vec;
            m_valid_d = 1'b1;
            asm_d     = '0;
          end else begin
            // The assembly register doubles as the holding slot while FULL.
            asm_d   = vec;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.m_ready) begin
          m_data_d = asm_q;
          asm_d    = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      asm_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      fe_q      <= fe_d;
    end
  end

  assign bus.s_ready = (state_q == FILL);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign frame_err   = fe_q;

`ifdef LOGICNET_PACKER_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (fe_q && (err_q != '1)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Randomized + directed bench for logicnet_input_packer against a queue-based vector model.
module tb_logicnet_input_packer;
  localparam int NF = 16, IN_W = 8, BW = 2, SHIFT = 4, VW = NF * BW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_err;
  logic [15:0] err_count;

  logicnet_input_packer_if #(.NUM_FEATURES(NF), .IN_W(IN_W), .BW(BW)) bus();

  logicnet_input_packer #(.NUM_FEATURES(NF), .IN_W(IN_W), .BW(BW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: vectors completed but not yet consumed (front = what m_data must show),
  // codes of the sample being assembled, pending frame_err pulse, error count.
  logic [VW-1:0] exp_q[$];
  int unsigned   cur[$];
  bit            fe_pend = 1'b0;
  int unsigned   cnt_m = 0;
  int            mr_mode = 0;

  function automatic int unsigned quant(input logic [IN_W-1:0] d);
    int unsigned t = int'(d) >> SHIFT;
    return (t > (2 ** BW - 1)) ? (2 ** BW - 1) : t;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cur.delete();
        fe_pend = 1'b0;
        cnt_m   = 0;
      end else begin
        bit rdy;
        rdy = (exp_q.size() < 2);
        check_eq("s_ready", bus.s_ready, rdy);
        check_eq("m_valid", bus.m_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) check_eq("m_data", bus.m_data, exp_q[0]);
        check_eq("frame_err", frame_err, fe_pend);
        check_eq("err_count", err_count, cnt_m);
`ifdef LOGICNET_PACKER_ERRCNT_EN
        if (fe_pend && cnt_m < 65535) cnt_m++;
`endif
        fe_pend = 1'b0;
        if (exp_q.size() > 0 && bus.m_ready) void'(exp_q.pop_front());
        if (bus.s_valid && rdy) begin
          cur.push_back(quant(bus.s_data));
          if (cur.size() == NF || bus.s_last) begin
            logic [VW-1:0] v;
            v = '0;
            foreach (cur[i]) v = v | (VW'(cur[i]) << (i * BW));
            exp_q.push_back(v);
            fe_pend = (bus.s_last != (cur.size() == NF));
            cur.delete();
          end
        end
      end
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mr_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'b0;
        default: bus.m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
    bit acc;
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    do begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    check_eq("beat_accept", acc, 1'b1);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, bus.m_valid, 1'b1);
  endtask

  initial begin
    logic [IN_W-1:0] pat[4];
    int unsigned exp_err;
    pat = '{8'h35, 8'h25, 8'h0F, 8'hF0};
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_ready", bus.s_ready, 1'b1);
    check_eq("rst_m_valid", bus.m_valid, 1'b0);
    check_eq("rst_m_data", bus.m_data, '0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_err_count", err_count, 16'd0);
    rst_n = 1'b1;
    idle(1);

    // Quantization: codes 3,2,0,3 per group of four slots, slot0 in LSBs.
    for (int i = 0; i < NF; i++) send_beat(pat[i % 4], i == NF - 1);
    wait_mvalid("quant_latency");
    check_eq("quant_data", bus.m_data, 32'hCBCBCBCB);
    idle(3);

    // Back-pressure: second sample parks while the first is held.
    mr_mode = 1;
    idle(1);
    for (int i = 0; i < NF; i++) send_beat(8'h10, i == NF - 1);
    for (int i = 0; i < NF; i++) send_beat(8'h20, i == NF - 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_hold_data", bus.m_data, 32'h55555555);
      check_eq("bp_s_ready_low", bus.s_ready, 1'b0);
    end
    mr_mode = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_second_data", bus.m_data, 32'hAAAAAAAA);
    check_eq("bp_s_ready_back", bus.s_ready, 1'b1);
    idle(3);

    // Early last on beat 3.
    for (int i = 0; i < 3; i++) send_beat(8'hFF, i == 2);
    wait_mvalid("early_latency");
    check_eq("early_data", bus.m_data, 32'h0000003F);
    check_eq("early_frame_err", frame_err, 1'b1);
    @(negedge clk);
`ifdef LOGICNET_PACKER_ERRCNT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    check_eq("early_err_count", err_count, exp_err);
    idle(2);

    // Missing last.
    for (int i = 0; i < NF; i++) send_beat(8'h30, 1'b0);
    wait_mvalid("miss_latency");
    check_eq("miss_data", bus.m_data, 32'hFFFFFFFF);
    check_eq("miss_frame_err", frame_err, 1'b1);
    idle(2);

    // Streaming: four back-to-back samples.
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < NF; i++) send_beat(IN_W'($urandom), i == NF - 1);
    idle(3);

    // Async reset mid-sample at beat 7.
    for (int i = 0; i < 6; i++) send_beat(IN_W'($urandom), 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    bus.s_last  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_s_ready", bus.s_ready, 1'b1);
    check_eq("mid_rst_m_valid", bus.m_valid, 1'b0);
    check_eq("mid_rst_m_data", bus.m_data, '0);
    check_eq("mid_rst_frame_err", frame_err, 1'b0);
    check_eq("mid_rst_err_count", err_count, 16'd0);
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < NF; i++) send_beat(IN_W'($urandom), i == NF - 1);
    wait_mvalid("post_rst_latency");
    idle(2);

    // Random samples: lengths 1..16 with last, 17 = no last; random gaps and m_ready.
    mr_mode = 2;
    for (int s = 0; s < 60; s++) begin
      int len;
      len = $urandom_range(1, NF + 1);
      for (int i = 0; i < NF && i < len; i++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        send_beat(IN_W'($urandom), (len <= NF) && (i == len - 1));
      end
    end
    mr_mode = 0;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
